// File: rtl/priority_scan_encoder_pkg.sv
// Shared types and constants for the priority scan encoder.
//   state_t      : controller states (IDLE, SCAN)
//   RR_FIXED     : mode constant, lowest set bit always wins
//   RR_ROUND     : mode constant, search starts at the persistent pointer
//   idx_width()  : index width for a given vector width
package priority_scan_encoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam bit RR_FIXED = 1'b0;
  localparam bit RR_ROUND = 1'b1;

  function automatic int idx_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/priority_scan_encoder_if.sv
// Handshake bundle between a vector source / index consumer and the encoder.
//   vec_i, vec_valid_i, vec_ready_o : hot-vector input handshake
//   idx_o, idx_valid_o, idx_ready_i : index output handshake
//   idx_last_o                      : current index is the final one of the vector
//   empty_o                         : pulse when an all-zero vector was accepted
//   busy_o                          : encoder is scanning
// Modports: slave = encoder side, master = source/consumer side.
interface priority_scan_encoder_if
  import priority_scan_encoder_pkg::*;
#(
  parameter int WIDTH = 8
) ();

  localparam int IDX_W = idx_width(WIDTH);

  logic [WIDTH-1:0] vec_i;
  logic             vec_valid_i;
  logic             vec_ready_o;
  logic [IDX_W-1:0] idx_o;
  logic             idx_valid_o;
  logic             idx_ready_i;
  logic             idx_last_o;
  logic             empty_o;
  logic             busy_o;

  modport slave (
    input  vec_i, vec_valid_i, idx_ready_i,
    output vec_ready_o, idx_o, idx_valid_o, idx_last_o, empty_o, busy_o
  );

  modport master (
    output vec_i, vec_valid_i, idx_ready_i,
    input  vec_ready_o, idx_o, idx_valid_o, idx_last_o, empty_o, busy_o
  );

endinterface

// File: rtl/priority_scan_encoder_prio_pick.sv
// Combinational first-set search over a vector.
//   vec_i    : vector to search
//   ptr_i    : start position for round-robin search
//   mode_i   : RR_FIXED = lowest set bit, RR_ROUND = first set bit at/after ptr_i, wrapping
//   idx_o    : selected index (0 when nothing is set)
//   found_o  : at least one bit set
//   single_o : exactly one bit set
module priority_scan_encoder_prio_pick
  import priority_scan_encoder_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic             mode_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o,
  output logic             single_o
);

  logic [IDX_W-1:0] lo_idx;
  logic [IDX_W-1:0] up_idx;
  logic             up_found;

  // Scanning downward lets the lowest matching bit overwrite earlier hits.
  always_comb begin
    lo_idx   = '0;
    up_idx   = '0;
    up_found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        lo_idx = IDX_W'(i);
        if (i >= int'(ptr_i)) begin
          up_idx   = IDX_W'(i);
          up_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    idx_o = lo_idx;
    if (mode_i == RR_ROUND && up_found) begin
      idx_o = up_idx;
    end
  end

  assign found_o  = |vec_i;
  assign single_o = found_o && ((vec_i & (vec_i - WIDTH'(1))) == '0);

endmodule

// File: rtl/priority_scan_encoder.sv
// Sequential priority scan encoder: accepts a hot vector and emits the index
// of every set bit, one per accepted output beat, lowest-first or round-robin.
//   clk_i  : clock, rising edge
//   rst_ni : synchronous active-low reset
//   bus    : handshake bundle (slave side), see priority_scan_encoder_if
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a new vector; zero vector pulses empty_o
// SCAN  | presenting indices from residue until the last one is taken
module priority_scan_encoder
  import priority_scan_encoder_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter bit RR_MODE = RR_FIXED
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  priority_scan_encoder_if.slave bus
);

  localparam int IDX_W = idx_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] residue_q, residue_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             empty_q, empty_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             pick_single;

  priority_scan_encoder_prio_pick #(
    .WIDTH (WIDTH)
  ) u_pick (
    .vec_i    (residue_q),
    .ptr_i    (ptr_q),
    .mode_i   (RR_MODE),
    .idx_o    (pick_idx),
    .found_o  (pick_found),
    .single_o (pick_single)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      residue_q <= '0;
      ptr_q     <= '0;
      empty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      residue_q <= residue_d;
      ptr_q     <= ptr_d;
      empty_q   <= empty_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    residue_d = residue_q;
    ptr_d     = ptr_q;
    empty_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.vec_valid_i) begin
          if (bus.vec_i != '0) begin
            residue_d = bus.vec_i;
            state_d   = SCAN;
          end else begin
            empty_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (bus.idx_ready_i && pick_found) begin
          residue_d[pick_idx] = 1'b0;
          if (RR_MODE == RR_ROUND) begin
            // Explicit wrap keeps non-power-of-2 widths correct.
            ptr_d = (pick_idx == IDX_W'(WIDTH - 1)) ? '0 : pick_idx + IDX_W'(1);
          end
          if (pick_single) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registered state, never on vec_i or idx_ready_i.
  assign bus.vec_ready_o = (state_q == IDLE);
  assign bus.busy_o      = (state_q == SCAN);
  assign bus.idx_valid_o = (state_q == SCAN);
  assign bus.idx_o       = (state_q == SCAN) ? pick_idx : '0;
  assign bus.idx_last_o  = (state_q == SCAN) && pick_single;
  assign bus.empty_o     = empty_q;

endmodule

// File: tb/tb_priority_scan_encoder.sv
module tb_priority_scan_encoder;
  import priority_scan_encoder_pkg::*;

  typedef struct packed {
    logic [2:0] idx;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] vec;
  logic       vec_valid;
  logic       idx_ready;

  int total = 0;
  int bad   = 0;

  beat_t      q [2][$];
  logic [2:0] mptr;

  priority_scan_encoder_if #(.WIDTH(8)) if_f ();
  priority_scan_encoder_if #(.WIDTH(8)) if_r ();

  assign if_f.vec_i       = vec;
  assign if_f.vec_valid_i = vec_valid;
  assign if_f.idx_ready_i = idx_ready;
  assign if_r.vec_i       = vec;
  assign if_r.vec_valid_i = vec_valid;
  assign if_r.idx_ready_i = idx_ready;

  priority_scan_encoder #(.WIDTH(8), .RR_MODE(RR_FIXED)) dut_f (
    .clk_i (clk), .rst_ni (rst_n), .bus (if_f.slave)
  );
  priority_scan_encoder #(.WIDTH(8), .RR_MODE(RR_ROUND)) dut_r (
    .clk_i (clk), .rst_ni (rst_n), .bus (if_r.slave)
  );

  always #5 clk = ~clk;

  logic [1:0] o_valid, o_last, o_vrdy, o_busy, o_empty;
  logic [2:0] o_idx [2];
  assign o_valid = {if_r.idx_valid_o, if_f.idx_valid_o};
  assign o_last  = {if_r.idx_last_o,  if_f.idx_last_o};
  assign o_vrdy  = {if_r.vec_ready_o, if_f.vec_ready_o};
  assign o_busy  = {if_r.busy_o,      if_f.busy_o};
  assign o_empty = {if_r.empty_o,     if_f.empty_o};
  assign o_idx[0] = if_f.idx_o;
  assign o_idx[1] = if_r.idx_o;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: m=0 lowest-first, m=1 round-robin from the model pointer.
  task automatic model_push(input logic [7:0] v);
    for (int m = 0; m < 2; m++) begin
      logic [7:0] res;
      int sel;
      res = v;
      while (res != 0) begin
        sel = -1;
        if (m == 1) begin
          for (int i = int'(mptr); i < 8; i++)
            if (sel < 0 && res[i]) sel = i;
        end
        for (int i = 0; i < 8; i++)
          if (sel < 0 && res[i]) sel = i;
        q[m].push_back('{idx: 3'(sel), last: ($countones(res) == 1)});
        res[sel] = 1'b0;
        if (m == 1) mptr = 3'((sel + 1) % 8);
      end
    end
  endtask

  // Compare presented beats against the scoreboard front; pop on handshake.
  task automatic cyc();
    for (int m = 0; m < 2; m++) begin
      if (o_valid[m] === 1'b1) begin
        if (q[m].size() == 0) begin
          check($sformatf("unexpected_beat_m%0d", m), 32'(o_idx[m]), 32'hFFFF);
        end else begin
          check($sformatf("idx_m%0d", m), 32'(o_idx[m]), 32'(q[m][0].idx));
          check($sformatf("last_m%0d", m), 32'(o_last[m]), 32'(q[m][0].last));
          if (idx_ready) void'(q[m].pop_front());
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input logic [7:0] v);
    check("vec_ready_before_f", 32'(o_vrdy[0]), 1);
    check("vec_ready_before_r", 32'(o_vrdy[1]), 1);
    vec       = v;
    vec_valid = 1'b1;
    model_push(v);
    cyc();
    vec_valid = 1'b0;
    vec       = 8'h00;
    if (v != 0) begin
      check("first_valid_latency", 32'(o_valid), 32'h3);
      check("busy_in_scan", 32'(o_busy), 32'h3);
      check("vec_ready_in_scan", 32'(o_vrdy), 32'h0);
    end
  endtask

  task automatic drain();
    idx_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (q[0].size() == 0 && q[1].size() == 0) break;
      cyc();
    end
    check("drain_timeout_left", 32'(q[0].size() + q[1].size()), 0);
    check("vec_ready_after_last", 32'(o_vrdy), 32'h3);
    check("valid_after_last", 32'(o_valid), 32'h0);
    check("busy_after_last", 32'(o_busy), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mptr      = '0;
    rst_n     = 1'b0;
    vec       = 8'h00;
    vec_valid = 1'b0;
    idx_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("rst_vec_ready", 32'(o_vrdy), 32'h3);
    check("rst_idx_valid", 32'(o_valid), 32'h0);
    check("rst_empty", 32'(o_empty), 32'h0);
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_last", 32'(o_last), 32'h0);
    check("rst_idx_f", 32'(o_idx[0]), 0);
    check("rst_idx_r", 32'(o_idx[1]), 0);
    rst_n = 1'b1;
    cyc();

    // Basic scan: 2, 5, 7 in both modes.
    send_vec(8'b1010_0100);
    check("a4_first_idx_f", 32'(o_idx[0]), 2);
    drain();

    // Backpressure on the first beat: index and last must hold.
    send_vec(8'b1010_0100);
    idx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_idx_f", 32'(o_idx[0]), 2);
      check("bp_hold_valid", 32'(o_valid), 32'h3);
      cyc();
    end
    drain();

    // Zero vector: single empty pulse, no beats.
    send_vec(8'h00);
    check("empty_pulse", 32'(o_empty), 32'h3);
    check("empty_no_valid", 32'(o_valid), 32'h0);
    cyc();
    check("empty_one_cycle", 32'(o_empty), 32'h0);
    check("empty_vec_ready", 32'(o_vrdy), 32'h3);
    check("empty_no_valid2", 32'(o_valid), 32'h0);

    // Round-robin pointer movement: 0C -> 2,3 ; 15 -> 4,0,2.
    send_vec(8'h0C);
    drain();
    send_vec(8'h15);
    check("rr_15_first", 32'(o_idx[1]), 4);
    drain();
    check("rr_model_ptr", 32'(mptr), 3);

    // Reset in the middle of a scan abandons the vector and clears ptr.
    send_vec(8'hFF);
    check("ff_first_r", 32'(o_idx[1]), 3);
    for (int i = 0; i < 3; i++) cyc();
    idx_ready = 1'b0;
    rst_n     = 1'b0;
    cyc();
    check("midrst_valid", 32'(o_valid), 32'h0);
    check("midrst_vec_ready", 32'(o_vrdy), 32'h3);
    check("midrst_busy", 32'(o_busy), 32'h0);
    q[0].delete();
    q[1].delete();
    mptr  = '0;
    rst_n = 1'b1;
    idx_ready = 1'b1;
    cyc();
    check("post_rst_no_valid", 32'(o_valid), 32'h0);
    send_vec(8'h02);
    check("post_rst_idx_r", 32'(o_idx[1]), 1);
    check("post_rst_last_r", 32'(o_last[1]), 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
